// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming 2D convolution block.
package conv_pkg;

    typedef enum logic {
        LOAD_W = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Default-configuration product type (DATA_W = COEF_W = 8).
    localparam int PROD_W_DEF = 16;
    typedef logic signed [PROD_W_DEF-1:0] prod_t;

    // Full-precision window sum: product width plus growth of a K*K-term addition.
    function automatic int acc_width(input int data_w, input int coef_w, input int k);
        return data_w + coef_w + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// K*K multiply stage followed by a registered adder tree; drains every cycle, no backpressure.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = acc_width(DATA_W, COEF_W, K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  launch,
    input  logic                  launch_last,
    input  logic [K*K*DATA_W-1:0] window,
    input  logic [K*K*COEF_W-1:0] weights,
    output logic                  valid_out,
    output logic                  last_out,
    output logic [ACC_W-1:0]      output_data
);
    localparam int KK     = K * K;
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_q [KK];
    logic                     s1_valid;
    logic                     s1_last;
    logic signed [ACC_W-1:0]  sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int e = 0; e < KK; e++) prod_q[e] <= '0;
        end else begin
            s1_valid <= launch;
            s1_last  <= launch && launch_last;
            if (launch) begin
                for (int e = 0; e < KK; e++) begin
                    prod_q[e] <= PROD_W'($signed(window[e*DATA_W +: DATA_W])) *
                                 PROD_W'($signed(weights[e*COEF_W +: COEF_W]));
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int e = 0; e < KK; e++) sum = sum + ACC_W'(prod_q[e]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
            output_data <= '0;
        end else begin
            valid_out <= s1_valid;
            last_out  <= s1_last;
            if (s1_valid) output_data <= sum;
        end
    end

endmodule

// File: rtl/conv_2d_square_input_square_kernel_stream.sv
// Streaming stride-1, no-padding 2D convolution: serial weight load, raster pixel stream,
// shift-register line buffer feeding a two-stage multiply/add pipeline.
module conv_2d_square_input_square_kernel_stream
    import conv_pkg::*;
#(
    parameter int IMG_N  = 8,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = acc_width(DATA_W, COEF_W, K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              weight_valid,
    output logic              weight_ready,
    input  logic [COEF_W-1:0] weight_data,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] input_data,
    output logic              valid_out,
    output logic [ACC_W-1:0]  output_data,
    output logic              last_out,
    output state_t            state_dbg
);
    localparam int KK    = K * K;
    localparam int SR_D  = (K - 1) * IMG_N + K;
    localparam int CNT_W = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int WI_W  = $clog2(KK);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IMG_N - 1);
    localparam logic [CNT_W-1:0] WIN_START = CNT_W'(K - 1);
    localparam logic [WI_W-1:0]  W_LAST    = WI_W'(KK - 1);

    state_t              state;
    logic [WI_W-1:0]     w_idx;
    logic [COEF_W-1:0]   w [KK];
    logic [DATA_W-1:0]   sr [SR_D];
    logic [CNT_W-1:0]    row;
    logic [CNT_W-1:0]    col;
    logic                frame_idle;
    logic                w_fire;
    logic                p_fire;
    logic                launch_q;
    logic                launch_last_q;
    logic [KK*DATA_W-1:0] window_flat;
    logic [KK*COEF_W-1:0] weight_flat;

    // Handshake: a beat transfers on the rising edge where valid and ready are both high;
    // ready never depends on valid, and a held beat stays offered until it transfers.
    assign frame_idle   = (row == '0) && (col == '0);
    assign weight_ready = (state == LOAD_W) || frame_idle;
    assign ready_in     = (state == STREAM);
    assign w_fire       = weight_valid && weight_ready;
    assign p_fire       = valid_in && ready_in;
    assign state_dbg    = state;

    // A reload may only start between frames, so in-flight windows always see one weight set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_W;
            w_idx <= '0;
            for (int i = 0; i < KK; i++) w[i] <= '0;
        end else if (w_fire) begin
            if (state == LOAD_W) begin
                w[w_idx] <= weight_data;
                if (w_idx == W_LAST) begin
                    w_idx <= '0;
                    state <= STREAM;
                end else begin
                    w_idx <= w_idx + WI_W'(1);
                end
            end else begin
                w[0]  <= weight_data;
                w_idx <= WI_W'(1);
                state <= LOAD_W;
            end
        end
    end

    // Launch decisions use the counters before this pixel advances them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row           <= '0;
            col           <= '0;
            launch_q      <= 1'b0;
            launch_last_q <= 1'b0;
            for (int i = 0; i < SR_D; i++) sr[i] <= '0;
        end else begin
            launch_q      <= p_fire && (row >= WIN_START) && (col >= WIN_START);
            launch_last_q <= p_fire && (row == LAST_IDX) && (col == LAST_IDX);
            if (p_fire) begin
                sr[0] <= input_data;
                for (int i = 1; i < SR_D; i++) sr[i] <= sr[i-1];
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= (row == LAST_IDX) ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

    // Newest pixel sits at tap 0, so tap (r,c) pairs with kernel element (K-1-r, K-1-c).
    always_comb begin
        window_flat = '0;
        weight_flat = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                window_flat[(kr*K+kc)*DATA_W +: DATA_W] = sr[(K-1-kr)*IMG_N + (K-1-kc)];
                weight_flat[(kr*K+kc)*COEF_W +: COEF_W] = w[kr*K+kc];
            end
        end
    end

    conv_window_mac #(
        .K      (K),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .launch      (launch_q),
        .launch_last (launch_last_q),
        .window      (window_flat),
        .weights     (weight_flat),
        .valid_out   (valid_out),
        .last_out    (last_out),
        .output_data (output_data)
    );

endmodule

// File: tb/tb_conv_2d_square_input_square_kernel_stream.sv
// Bench for the streaming 2D convolution: table of weight/pixel/expected frames plus corner sequences.
module tb_conv_2d_square_input_square_kernel_stream;
    import conv_pkg::*;

    localparam int N  = 4;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int AW = DW + CW + $clog2(K * K);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          weight_valid = 1'b0;
    logic          weight_ready;
    logic [CW-1:0] weight_data = '0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [DW-1:0] input_data = '0;
    logic          valid_out;
    logic [AW-1:0] output_data;
    logic          last_out;
    state_t        state_dbg;

    conv_2d_square_input_square_kernel_stream #(
        .IMG_N  (N),
        .K      (K),
        .DATA_W (DW),
        .COEF_W (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .weight_data  (weight_data),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .input_data   (input_data),
        .valid_out    (valid_out),
        .output_data  (output_data),
        .last_out     (last_out),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_q[$];
    logic          last_q[$];
    int            cyc_q[$];

    typedef struct {
        logic [8:0][CW-1:0]  w;
        logic [15:0][DW-1:0] pix;
        logic [3:0][AW-1:0]  ex;
        bit                  gaps;
    } vec_t;

    vec_t vecs[6];
    logic [8:0][CW-1:0]  w_ones;
    logic [8:0][CW-1:0]  w_twos;
    logic [15:0][DW-1:0] pix_ramp;
    logic [3:0][AW-1:0]  ex_ones;
    logic [3:0][AW-1:0]  ex_twos;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard: pop one expectation per output pulse.
    logic [AW-1:0] e_data;
    logic          e_last;
    int            e_cyc;
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got=%0d want=none", $signed(output_data));
            end else begin
                e_data = exp_q.pop_front();
                e_last = last_q.pop_front();
                e_cyc  = cyc_q.pop_front();
                check("output_data", $signed(output_data), $signed(e_data));
                check("last_out", last_out, e_last);
                check("latency_cycle", cyc, e_cyc);
            end
        end
    end

    task automatic drive_pixel(input logic [DW-1:0] d, input bit has, input logic [AW-1:0] ev,
                               input bit lst);
        int guard = 0;
        @(negedge clk);
        valid_in   = 1'b1;
        input_data = d;
        #1;
        while (!ready_in && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        total++;
        if (!ready_in) begin
            bad++;
            $display("FAIL pixel_accept: got=ready_in 0 want=ready_in 1 within 50 cycles");
        end else if (has) begin
            exp_q.push_back(ev);
            last_q.push_back(lst);
            cyc_q.push_back(cyc + 3);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0][DW-1:0] pix, input logic [3:0][AW-1:0] ex,
                              input int start, input bit gaps);
        for (int p = start; p < N * N; p++) begin
            bit has;
            int ei;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            has = (p / N >= K - 1) && (p % N >= K - 1);
            ei  = has ? (p / N - (K - 1)) * (N - K + 1) + (p % N - (K - 1)) : 0;
            drive_pixel(pix[p], has, ex[ei], p == N * N - 1);
        end
    endtask

    task automatic load_weights(input logic [8:0][CW-1:0] w, input int start);
        for (int i = start; i < K * K; i++) begin
            int guard = 0;
            @(negedge clk);
            weight_valid = 1'b1;
            weight_data  = w[i];
            #1;
            while (!weight_ready && guard < 50) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (!weight_ready) begin
                total++;
                bad++;
                $display("FAIL weight_accept: got=weight_ready 0 want=weight_ready 1");
            end
            @(posedge clk);
            #1;
            weight_valid = 1'b0;
            if (i < K * K - 1) begin
                check("ready_in_during_load", ready_in, 0);
            end else begin
                check("ready_in_after_load", ready_in, 1);
                check("state_after_load", state_dbg, STREAM);
            end
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 9; i++) begin
            w_ones[i] = CW'(1);
            w_twos[i] = CW'(2);
        end
        for (int p = 0; p < 16; p++) pix_ramp[p] = DW'(p + 1);
        ex_ones = {AW'(99), AW'(90), AW'(63), AW'(54)};
        ex_twos = {AW'(198), AW'(180), AW'(126), AW'(108)};

        vecs[0].w = w_ones; vecs[0].pix = pix_ramp; vecs[0].ex = ex_ones; vecs[0].gaps = 1'b0;
        for (int i = 0; i < 9; i++) vecs[1].w[i] = (i == 4) ? CW'(1) : CW'(0);
        vecs[1].pix = pix_ramp;
        vecs[1].ex  = {AW'(11), AW'(10), AW'(7), AW'(6)};
        vecs[1].gaps = 1'b0;
        for (int i = 0; i < 9; i++) vecs[2].w[i] = CW'(-1);
        for (int p = 0; p < 16; p++) vecs[2].pix[p] = DW'(127);
        for (int j = 0; j < 4; j++) vecs[2].ex[j] = AW'(-1143);
        vecs[2].gaps = 1'b0;
        for (int i = 0; i < 9; i++) vecs[3].w[i] = CW'(-128);
        for (int p = 0; p < 16; p++) vecs[3].pix[p] = DW'(-128);
        for (int j = 0; j < 4; j++) vecs[3].ex[j] = AW'(147456);
        vecs[3].gaps = 1'b0;
        vecs[4].w = w_ones; vecs[4].pix = pix_ramp; vecs[4].ex = ex_ones; vecs[4].gaps = 1'b1;
        vecs[5].w = w_twos; vecs[5].pix = pix_ramp; vecs[5].ex = ex_twos; vecs[5].gaps = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_weight_ready", weight_ready, 1);
        check("rst_ready_in", ready_in, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_last_out", last_out, 0);
        check("rst_output_data", output_data, 0);
        check("rst_state", state_dbg, LOAD_W);
        rst = 1'b0;

        // Table-driven frames, each preceded by a full weight reload
        for (int t = 0; t < 6; t++) begin
            load_weights(vecs[t].w, 0);
            send_frame(vecs[t].pix, vecs[t].ex, 0, vecs[t].gaps);
            wait_drain();
        end

        // Weight offered mid-frame must be refused and leave the frame untouched
        load_weights(w_ones, 0);
        for (int p = 0; p < 16; p++) begin
            bit has;
            int ei;
            weight_valid = (p >= 5 && p <= 14);
            weight_data  = CW'(5);
            has = (p / N >= K - 1) && (p % N >= K - 1);
            ei  = has ? (p / N - (K - 1)) * (N - K + 1) + (p % N - (K - 1)) : 0;
            drive_pixel(pix_ramp[p], has, ex_ones[ei], p == 15);
            if (p >= 5 && p <= 14) check("weight_ready_mid_frame", weight_ready, 0);
        end
        weight_valid = 1'b0;
        wait_drain();
        check("state_after_refused_weight", state_dbg, STREAM);

        // Weight and pixel together at frame start: both taken, then reload finishes
        @(negedge clk);
        weight_valid = 1'b1;
        weight_data  = CW'(2);
        valid_in     = 1'b1;
        input_data   = DW'(1);
        #1;
        check("both_ready_at_idle", {weight_ready, ready_in}, 2'b11);
        @(posedge clk);
        #1;
        weight_valid = 1'b0;
        valid_in     = 1'b0;
        check("state_after_shared_beat", state_dbg, LOAD_W);
        check("ready_in_after_shared_beat", ready_in, 0);
        load_weights(w_twos, 1);
        send_frame(pix_ramp, ex_twos, 1, 1'b0);
        wait_drain();

        // Reset with a result in flight: it is dropped and weights must be reloaded
        load_weights(w_ones, 0);
        for (int p = 0; p < 11; p++) drive_pixel(pix_ramp[p], p == 10, ex_ones[0], 1'b0);
        rst = 1'b1;
        exp_q.delete();
        last_q.delete();
        cyc_q.delete();
        #1;
        check("midrst_ready_in", ready_in, 0);
        check("midrst_weight_ready", weight_ready, 1);
        check("midrst_state", state_dbg, LOAD_W);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_valid_out", valid_out, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_in", ready_in, 0);
        load_weights(w_ones, 0);
        send_frame(pix_ramp, ex_ones, 0, 1'b0);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
